// File: rtl/wb_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator_if
// Brief    : Requester command/response handshake plus Wishbone classic
//            master signals for wb_initiator.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_initiator_if;

    // Command channel from the local requester
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    // Response channel back to the requester
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    // Wishbone classic master side
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    // Initiator side (the bridge itself)
    modport master (
        input  cmd_valid,
        input  cmd_we,
        input  cmd_adr,
        input  cmd_dat,
        input  cmd_sel,
        output cmd_ready,
        output rsp_valid,
        input  rsp_ready,
        output rsp_dat,
        output rsp_err,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_adr_o,
        output wbm_dat_o,
        output wbm_sel_o,
        input  wbm_dat_i,
        input  wbm_ack_i
    );

    // Environment side (requester plus Wishbone slave)
    modport slave (
        output cmd_valid,
        output cmd_we,
        output cmd_adr,
        output cmd_dat,
        output cmd_sel,
        input  cmd_ready,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_dat,
        input  rsp_err,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        input  wbm_sel_o,
        output wbm_dat_i,
        output wbm_ack_i
    );

endinterface
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Brief    : Single-outstanding Wishbone classic master with ack timeout,
//            valid/ready command and response channels and txn/err counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    wb_initiator_if.master bus,
    output logic [15:0]    txn_cnt,
    output logic [7:0]     err_cnt
);

    localparam logic [15:0] c_wait_last = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;
    logic        w_rsp_take;

    logic        r_cmd_ready;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [15:0] r_wait;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic [15:0] r_txn_cnt;
    logic [7:0]  r_err_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transaction-event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        w_rsp_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_cmd_ready is low for the first cycle out of reset
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.wbm_ack_i) begin
                    w_ack        = 1'b1;
                    w_next_state = ST_RESP;
                end else if (r_wait == c_wait_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_take   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus, response and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_sel       <= 4'd0;
            r_wait      <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_txn_cnt   <= 16'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_cmd_ready <= (w_next_state == ST_IDLE);

            if (w_accept) begin
                r_we   <= bus.cmd_we;
                r_adr  <= bus.cmd_adr;
                r_dat  <= bus.cmd_dat;
                r_sel  <= bus.cmd_sel;
                r_cyc  <= 1'b1;
                r_wait <= 16'd0;
            end

            if ((r_state == ST_BUS) && !bus.wbm_ack_i) begin
                r_wait <= r_wait + 16'd1;
            end

            if (w_ack || w_timeout) begin
                r_cyc       <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_timeout;
                r_rsp_dat   <= (w_ack && !r_we) ? bus.wbm_dat_i : 32'd0;
                r_txn_cnt   <= r_txn_cnt + 16'd1;
                if (w_timeout && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end

            if (w_rsp_take) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // A single register drives both cyc and stb so stb can never lead cyc
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_we_o  = r_we;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_dat;
    assign bus.wbm_sel_o = r_sel;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_dat   = r_rsp_dat;
    assign bus.rsp_err   = r_rsp_err;

    assign txn_cnt = r_txn_cnt;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire
